// File: rtl/router_pkg.sv
// router_pkg: shared sizing and input-port state encoding for modport_router
package router_pkg;
  localparam int NPORTS = 16;
  localparam int ADDR_BITS = 4;
  localparam int PAD_CYCLES = 5;
  typedef enum logic [2:0] {IDLE, ADDR, PAD, PAYLOAD, DROP} in_state_e;
endpackage

// File: rtl/router_inport.sv
// router_inport: per-port framing FSM, LSB-first address capture and pad timing
module router_inport #(
  parameter int ADDR_BITS = router_pkg::ADDR_BITS,
  parameter int PAD_CYCLES = router_pkg::PAD_CYCLES
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 din,
  input  logic                 frame_n,
  input  logic                 win,
  output logic                 req,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 in_payload,
  output logic                 active
);
  import router_pkg::*;
  localparam int CW = $clog2(PAD_CYCLES > ADDR_BITS ? PAD_CYCLES : ADDR_BITS);
  // address bit 0 is taken while still IDLE, so ADDR only lasts ADDR_BITS-1 cycles
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BITS - 2);
  localparam logic [CW-1:0] PAD_LAST = CW'(PAD_CYCLES - 1);
  in_state_e state, state_nx;
  logic [CW-1:0] cnt;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:          state_nx = frame_n ? IDLE : ADDR;
      ADDR:          state_nx = frame_n ? IDLE : (cnt == ADDR_LAST) ? PAD : ADDR;
      PAD:           state_nx = frame_n ? IDLE : (req && !win) ? DROP : (cnt == PAD_LAST) ? PAYLOAD : PAD;
      PAYLOAD, DROP: state_nx = frame_n ? IDLE : state;
      default:       state_nx = IDLE;
    endcase
  end
  always_comb begin
    req = state == PAD && cnt == '0 && !frame_n;
    in_payload = state == PAYLOAD;
    active = state == PAD || state == PAYLOAD;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cnt <= '0;
      addr <= '0;
    end else begin
      cnt <= (state_nx == state) ? cnt + 1'b1 : '0;
      if (state == IDLE || state == ADDR) addr <= {din, addr[ADDR_BITS-1:1]};
    end
endmodule

// File: rtl/modport_router.sv
// modport_router: 16x16 cut-through serial packet switch with per-output round-robin arbitration
module modport_router #(
  parameter int NPORTS = router_pkg::NPORTS,
  parameter int ADDR_BITS = router_pkg::ADDR_BITS,
  parameter int PAD_CYCLES = router_pkg::PAD_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NPORTS-1:0] din,
  input  logic [NPORTS-1:0] frame_n,
  input  logic [NPORTS-1:0] valid_n,
  output logic [NPORTS-1:0] dout,
  output logic [NPORTS-1:0] valido_n,
  output logic [NPORTS-1:0] frameo_n,
  output logic [NPORTS-1:0] busy_n
);
  import router_pkg::*;
  logic [NPORTS-1:0] req, in_payload, active, win, busy, gnt, fwd, rq;
  logic [NPORTS-1:0][ADDR_BITS-1:0] addr, owner, ptr, widx;
  logic [ADDR_BITS:0] pick;
  // returns {found, index}; the first requester at or after p wins
  function automatic logic [ADDR_BITS:0] rr_pick(input logic [NPORTS-1:0] r, input logic [ADDR_BITS-1:0] p);
    logic [ADDR_BITS-1:0] idx;
    rr_pick = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      idx = p + ADDR_BITS'(k);
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction
  for (genvar g = 0; g < NPORTS; g++) begin : g_in
    router_inport #(.ADDR_BITS(ADDR_BITS), .PAD_CYCLES(PAD_CYCLES)) u_in (
      .clock(clock),
      .reset(reset),
      .din(din[g]),
      .frame_n(frame_n[g]),
      .win(win[g]),
      .req(req[g]),
      .addr(addr[g]),
      .in_payload(in_payload[g]),
      .active(active[g])
    );
  end
  always_comb begin
    win = '0;
    gnt = '0;
    fwd = '0;
    rq = '0;
    pick = '0;
    widx = '0;
    for (int o = 0; o < NPORTS; o++) begin
      for (int i = 0; i < NPORTS; i++) rq[i] = req[i] && addr[i] == ADDR_BITS'(o);
      pick = rr_pick(rq, ptr[o]);
      widx[o] = pick[ADDR_BITS-1:0];
      gnt[o] = pick[ADDR_BITS] && !busy[o];
      if (gnt[o]) win[widx[o]] = 1'b1;
      fwd[o] = busy[o] && in_payload[owner[o]];
    end
  end
  // a grant is held until the owning input is no longer in its granted packet
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      busy <= '0;
      owner <= '0;
      ptr <= '0;
      dout <= '0;
      valido_n <= '1;
      frameo_n <= '1;
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        if (gnt[o]) begin
          busy[o] <= 1'b1;
          owner[o] <= widx[o];
          ptr[o] <= widx[o] + 1'b1;
        end else if (busy[o] && !active[owner[o]]) busy[o] <= 1'b0;
        dout[o] <= fwd[o] && din[owner[o]];
        valido_n[o] <= !fwd[o] || valid_n[owner[o]];
        frameo_n[o] <= !fwd[o] || frame_n[owner[o]];
      end
    end
  assign busy_n = ~busy;
endmodule

// File: tb/tb_modport_router.sv
// tb_modport_router: randomized packet traffic checked against a packet-level reference model
module tb_modport_router;
  localparam int N = 16;
  logic clock = 0, reset = 1;
  logic [N-1:0] din = '0, frame_n = '1, valid_n = '1;
  logic [N-1:0] dout, valido_n, frameo_n, busy_n;
  int vectors = 0, miscompares = 0;
  bit run = 0;
  logic [2:0] sq [N][$];
  logic [63:0] exp_q [$];
  logic [63:0] em;
  logic [N-1:0] df, dv, dd;
  logic [2:0] dx;
  bit inpkt [N];
  bit gr [N];
  int pos [N];
  logic [3:0] ad [N];
  int own [N];
  int ptr [N];

  modport_router dut (
    .clock(clock), .reset(reset), .din(din), .frame_n(frame_n), .valid_n(valid_n),
    .dout(dout), .valido_n(valido_n), .frameo_n(frameo_n), .busy_n(busy_n)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      inpkt[i] = 0; gr[i] = 0; pos[i] = 0; ad[i] = '0; own[i] = -1; ptr[i] = 0;
    end
  endtask

  // positions are counted from the frame-start cycle; outputs follow inputs by one cycle
  task automatic model_step(input logic [N-1:0] f, input logic [N-1:0] v, input logic [N-1:0] d);
    logic [N-1:0] rq [N];
    logic [N-1:0] nd, nv, nf, nb;
    int nown [N];
    int w;
    nd = '0; nv = '1; nf = '1; nb = '1;
    for (int o = 0; o < N; o++) rq[o] = '0;
    for (int i = 0; i < N; i++) begin
      if (!inpkt[i]) begin
        if (!f[i]) begin inpkt[i] = 1; pos[i] = 0; ad[i] = '0; gr[i] = 0; end
      end else pos[i]++;
      if (inpkt[i] && pos[i] < 4) ad[i][pos[i][1:0]] = d[i];
      if (inpkt[i] && pos[i] == 4 && !f[i]) rq[ad[i]][i] = 1'b1;
    end
    for (int o = 0; o < N; o++) begin
      nown[o] = own[o];
      if (own[o] >= 0 && inpkt[own[o]] && gr[own[o]] && pos[own[o]] >= 9) begin
        nd[o] = d[own[o]]; nv[o] = v[own[o]]; nf[o] = f[own[o]];
      end
      if (own[o] >= 0 && !(inpkt[own[o]] && gr[own[o]])) nown[o] = -1;
      w = -1;
      if (own[o] < 0)
        for (int k = N - 1; k >= 0; k--) if (rq[o][(ptr[o] + k) % N]) w = (ptr[o] + k) % N;
      for (int i = 0; i < N; i++) if (rq[o][i] && i == w) gr[i] = 1;
      if (w >= 0) begin nown[o] = w; ptr[o] = (w + 1) % N; end
    end
    for (int i = 0; i < N; i++) if (inpkt[i] && pos[i] >= 1 && f[i]) inpkt[i] = 0;
    for (int o = 0; o < N; o++) begin own[o] = nown[o]; nb[o] = own[o] < 0; end
    exp_q.push_back({nd, nv, nf, nb});
  endtask

  task automatic add_idle(input int i, input int n);
    for (int k = 0; k < n; k++) sq[i].push_back(3'b110);
  endtask

  task automatic add_pkt(input int i, input int a, input int n, input bit gap, input int abort_at, input logic [31:0] pl);
    logic b;
    for (int k = 0; k < 9; k++) begin
      if (k == abort_at) begin sq[i].push_back(3'b110); return; end
      b = 1'($urandom);
      if (k < 4) b = a[k];
      sq[i].push_back({2'b01, b});
    end
    for (int k = 0; k < n; k++) begin
      while (gap && $urandom_range(0, 2) == 0) sq[i].push_back({2'b01, 1'($urandom)});
      sq[i].push_back({k == n - 1, 1'b0, pl[k]});
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (sq[i].size() > 0) return 1;
    return 0;
  endfunction

  task automatic drain();
    int b = 0;
    while (pending() && b < 4000) begin @(negedge clock); b++; end
    if (b >= 4000) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: got %0d cycles required < 4000", b);
    end
    repeat (3) @(negedge clock);
    @(posedge clock);
  endtask

  always @(negedge clock) if (run) begin
    for (int i = 0; i < N; i++) begin
      if (sq[i].size() > 0) dx = sq[i].pop_front();
      else dx = 3'b110;
      {df[i], dv[i], dd[i]} = dx;
    end
    frame_n = df; valid_n = dv; din = dd;
    model_step(df, dv, dd);
  end

  always @(posedge clock) begin
    #1;
    if (run && exp_q.size() > 0) begin
      em = exp_q.pop_front();
      chk($sformatf("out@%0t {dout,valido_n,frameo_n,busy_n}", $time), {dout, valido_n, frameo_n, busy_n}, em);
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_dout", {48'b0, dout}, 64'h0);
    chk("rst_valido_n", {48'b0, valido_n}, 64'hFFFF);
    chk("rst_frameo_n", {48'b0, frameo_n}, 64'hFFFF);
    chk("rst_busy_n", {48'b0, busy_n}, 64'hFFFF);
    @(posedge clock); #3;
    reset = 0; run = 1;
    add_pkt(3, 5, 8, 0, -1, 32'hA5);
    drain();
    for (int r = 0; r < 2; r++) begin
      add_pkt(2, 9, 6, 0, -1, $urandom);
      add_pkt(7, 9, 6, 0, -1, $urandom);
      drain();
    end
    add_pkt(10, 12, 12, 1, -1, $urandom);
    drain();
    for (int i = 0; i < N; i++) add_pkt(i, 15 - i, 10, 0, -1, $urandom);
    drain();
    add_pkt(4, 6, 8, 0, 6, $urandom);
    add_pkt(4, 6, 8, 0, -1, $urandom);
    drain();
    for (int r = 0; r < 30; r++)
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 1) == 1) begin
          add_idle(i, $urandom_range(0, 3));
          add_pkt(i, $urandom_range(0, 3), $urandom_range(1, 12), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 8)) : -1, $urandom);
        end
    drain();
    add_pkt(0, 1, 32, 0, -1, $urandom);
    add_pkt(5, 14, 32, 1, -1, $urandom);
    repeat (20) @(posedge clock);
    #3;
    chk("pre_rst_busy_n1", {63'b0, busy_n[1]}, 64'h0);
    run = 0; reset = 1;
    #1;
    chk("mid_rst_dout", {48'b0, dout}, 64'h0);
    chk("mid_rst_valido_n", {48'b0, valido_n}, 64'hFFFF);
    chk("mid_rst_frameo_n", {48'b0, frameo_n}, 64'hFFFF);
    chk("mid_rst_busy_n", {48'b0, busy_n}, 64'hFFFF);
    exp_q.delete();
    for (int i = 0; i < N; i++) sq[i].delete();
    model_reset();
    frame_n = '1; valid_n = '1; din = '0;
    repeat (2) @(posedge clock); #3;
    reset = 0; run = 1;
    add_pkt(0, 1, 8, 0, -1, $urandom);
    add_pkt(6, 1, 8, 1, -1, $urandom);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/modport_router.md
# modport_router

16×16 serial packet router behind the `router_io` modport. Each of 16 serial input ports carries framed packets with a 4-bit destination address. The block switches each packet, cut-through, to the addressed output port, and arbitrates round-robin among inputs that contend for the same output. It sits between the per-port serial links and the downstream output links.

## Interface
Parameters:
- `NPORTS`, 16: number of input and output ports.
- `ADDR_BITS`, 4: address width, `log2(NPORTS)`.
- `PAD_CYCLES`, 5: padding cycles between address and payload.

Ports:
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `din` input 16: serial data, one bit per input port.
- `frame_n` input 16: active-low frame per input port.
- `valid_n` input 16: active-low payload-valid per input port.
- `dout` output 16: serial data per output port.
- `valido_n` output 16: active-low valid per output port.
- `frameo_n` output 16: active-low frame per output port.
- `busy_n` output 16: active-low, output port allocated.

## Operation
- Input packet format on port i, with frame start at cycle t0 (first cycle `frame_n[i]=0` while the port is idle):
  - t0..t0+3: address bits, LSB first, sampled from `din[i]`.
  - t0+4..t0+8: padding; `valid_n` high; `din` ignored.
  - t0+9 onward: payload. A bit is carried only when `valid_n[i]=0`. The last bit has `frame_n[i]=1` and `valid_n[i]=0`.
- Input FSM states and transitions:
  - IDLE → ADDR when `frame_n=0`.
  - ADDR → PAD after 4 bits.
  - PAD → PAYLOAD after 5 cycles.
  - PAYLOAD → IDLE on the last bit.
  - DROP → IDLE when `frame_n=1`.
- Arbitration:
  - Each input requests output `addr` in its first PAD cycle (t0+4).
  - An output is grantable only while `busy_n[o]=1`.
  - Simultaneous requesters for the same output are served round-robin. The pointer per output starts at 0 and advances to winner+1.
- A losing or blocked request sends the input to DROP. The whole packet is discarded; there is no buffering and no retry.
- Forwarding (granted input i → output o), for every cycle input i is in PAYLOAD: `dout[o]<=din[i]`, `valido_n[o]<=valid_n[i]`, `frameo_n[o]<=frame_n[i]`.
- An idle output drives `dout=0`, `valido_n=1`, `frameo_n=1`.
- Protocol error: `frame_n` high during ADDR or PAD aborts the packet. The port returns to IDLE, its grant (if any) is released, and the output stays idle.
- Reset values: all outputs at idle values, `busy_n=16'hFFFF`, all FSMs in IDLE, round-robin pointers at 0.
- Reset mid-packet drops all packets immediately.

## Timing
- Grant is registered at the end of t0+4; `busy_n[o]=0` from t0+5.
- Data latency is 1 cycle. Input payload at cycle t appears on the output at t+1. The first output payload cycle is t0+10, with `frameo_n=0`.
- The last input bit at tL appears at tL+1 with `frameo_n=1` and `valido_n=0`.
- The grant is released at the end of tL+1; `busy_n[o]=1` from tL+2.
- A new request evaluated in the same cycle as a release sees the output busy (it is dropped).
- Back-to-back packets: a new frame may start on input i at tL+1.

## Structure
- Package `router_pkg`: `NPORTS`, `ADDR_BITS`, `PAD_CYCLES`, and the `in_state_e` enum {IDLE, ADDR, PAD, PAYLOAD, DROP}.
- Sub-module `router_inport`, instantiated ×16. It holds the input FSM, the address shift register and the pad counter, and outputs `req`, `addr`, `in_payload`.
- Top level holds the 16 round-robin arbiters, the grant/owner registers and the output crossbar muxes.

## Test plan
- Single packet: input 3 sends to address 5, payload 8'hA5 LSB-first. Output 5 shows 8 valid bits of 8'hA5 starting at t0+10; `frameo_n[5]` rises with the last bit; `busy_n[5]` is 0 from t0+5 to tL+1.
- Contention: inputs 2 and 7 both start to output 9 in the same cycle. Input 2 is forwarded and input 7 is dropped. A repeat of the same pair gives input 7 the grant (round-robin).
- Gaps: payload with `valid_n=1` gaps is mirrored cycle-for-cycle with 1-cycle latency.
- Parallel traffic: 16 inputs to 16 distinct outputs (i → 15−i) all forward concurrently with no loss.
- Abort: `frame_n` goes high at t0+6. Output stays idle, `busy_n` returns to 1, and the next packet on that input routes correctly.
- Reset: asserting `reset` mid-payload drives all outputs to idle values immediately (`busy_n=FFFF`, `valido_n=FFFF`, `frameo_n=FFFF`, `dout=0`).
